// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Sequencer for the loadable left-shift register. Accepts a W-bit word on a
//   valid/ready handshake, loads it into the external register, then shifts it
//   out MSB-first one bit per cycle and pulses done at the end.
//
//   Optional feature macro: SHIFT_SEQ_CTRL_PARITY_EN
//     defined   -> even parity of the accepted word is emitted as one extra
//                  serial bit after the data bits (PAR state)
//     undefined -> SHIFT goes straight to DONE
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     in_data/valid     word to serialize and its valid strobe
//     in_ready          block can accept a word (IDLE only)
//     abort             cancel the word in flight (SHIFT/PAR only)
//     reg_d/ld/shl/clr  control and data inputs of the shift register
//     reg_shl_in        register serial input, tied to 0
//     reg_q             register output
//     ser_out/valid     serial bit stream
//     busy, done        word in flight / one-cycle completion pulse
//
//   state | meaning
//   IDLE  | waiting for a word, in_ready high
//   SHIFT | emitting data bits from reg_q MSB, cnt = bit index
//   PAR   | emitting the parity bit (parity build only)
//   DONE  | done pulse, register cleared
module shift_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [W-1:0] reg_d,
  output logic         reg_ld,
  output logic         reg_shl,
  output logic         reg_clr,
  output logic         reg_shl_in,
  input  logic [W-1:0] reg_q,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  assign reg_shl_in = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (rst)
      par <= 1'b0;
    else if (in_valid && in_ready)
      par <= ^in_data;
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    reg_d     = '0;
    reg_ld    = 1'b0;
    reg_shl   = 1'b0;
    reg_clr   = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (rst) begin
      reg_clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            reg_ld    = 1'b1;
            reg_d     = in_data;
            state_nxt = SHIFT;
            cnt_nxt   = '0;
          end
        end
        SHIFT: begin
          busy = 1'b1;
          if (abort) begin
            reg_clr   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ser_out   = reg_q[W-1];
            ser_valid = 1'b1;
            reg_shl   = 1'b1;
            // The register shifts its d input, so q is looped back through d.
            reg_d     = reg_q;
            if (cnt == LAST) begin
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
              state_nxt = PAR;
`else
              state_nxt = DONE;
`endif
            end else begin
              // Held at LAST on exit so cnt only wraps on entry to SHIFT.
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        PAR: begin
          busy = 1'b1;
          if (abort) begin
            reg_clr   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ser_out   = par;
            ser_valid = 1'b1;
            state_nxt = DONE;
          end
        end
`endif
        DONE: begin
          done      = 1'b1;
          reg_clr   = 1'b1;
          busy      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
